// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: function codes,
// FSM states and the operand-shaping helper.
package alu_sched_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] FUNC_ADD = 3'd0;
    localparam logic [OP_W-1:0] FUNC_SUB = 3'd1;
    localparam logic [OP_W-1:0] FUNC_SLL = 3'd2;
    localparam logic [OP_W-1:0] FUNC_XOR = 3'd3;
    localparam logic [OP_W-1:0] FUNC_SRL = 3'd4;
    localparam logic [OP_W-1:0] FUNC_SRA = 3'd5;
    localparam logic [OP_W-1:0] FUNC_OR  = 3'd6;
    localparam logic [OP_W-1:0] FUNC_AND = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        logic res;
        case (op)
            FUNC_SLL, FUNC_SRL, FUNC_SRA: res = 1'b1;
            default:                      res = 1'b0;
        endcase
        return res;
    endfunction

    // Shift ops only ever see a 5-bit shift amount on the B operand.
    function automatic logic [DATA_W-1:0] shape_b(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        if (is_shift(op)) begin
            res = {27'd0, b[4:0]};
        end else begin
            res = b;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Bundle of requester-side and ALU-side signals of the scheduler.
// master = scheduler view, slave = requesters plus ALU view.
interface alu_sched_if
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [OP_W*NUM_REQ-1:0]   req_op;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      alu_valid;
    logic [OP_W-1:0]           alu_ctrl;
    logic [DATA_W-1:0]         alu_in_A;
    logic [DATA_W-1:0]         alu_in_B;
    logic [DATA_W-1:0]         alu_out;

    modport master (
        input  req_valid, req_op, req_a, req_b, alu_out,
        output req_ready, rsp_valid, rsp_id, rsp_data,
               alu_valid, alu_ctrl, alu_in_A, alu_in_B
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, alu_out,
        input  req_ready, rsp_valid, rsp_id, rsp_data,
               alu_valid, alu_ctrl, alu_in_A, alu_in_B
    );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at ptr_i (highest priority)
// and returns a one-hot grant for the first pending one.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);
    localparam int SW = ID_W + 1;

    logic [SW-1:0] sum_s;
    logic [SW-1:0] idx_s;
    logic          found_s;

    // Rotating priority scan with modulo wrap for any NUM_REQ.
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, ptr_i} + SW'(i);
            idx_s = (sum_s >= SW'(NUM_REQ)) ? (sum_s - SW'(NUM_REQ)) : sum_s;
            if (!found_s && req_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters; reloads
// the ALU function only when it differs from the one last programmed.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_sched_if.master  bus_if
);
    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_s;
    logic [NUM_REQ-1:0]  ready_s;
    logic                accept_s;
    logic [ID_W-1:0]     win_id_s;
    logic [OP_W-1:0]     win_op_s;
    logic [DATA_W-1:0]   win_a_s;
    logic [DATA_W-1:0]   win_b_s;

    logic [ID_W-1:0]     ptr_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [ID_W-1:0]     id_q;
    logic [OP_W-1:0]     cur_op_q;
    logic                cfg_ok_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic                rsp_valid_q;
    logic                alu_valid_q;
    logic [OP_W-1:0]     alu_ctrl_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i   (bus_if.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s)
    );

    // Encode the one-hot grant and select the winner's op and operands.
    always_comb begin
        win_id_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                win_id_s = ID_W'(i);
            end else begin
                win_id_s = win_id_s;
            end
        end
        win_op_s = bus_if.req_op[OP_W*win_id_s +: OP_W];
        win_a_s  = bus_if.req_a[DATA_W*win_id_s +: DATA_W];
        win_b_s  = bus_if.req_b[DATA_W*win_id_s +: DATA_W];
    end

    // Next-state logic; accepting happens only in IDLE.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        ready_s  = '0;
        case (state_q)
            IDLE: begin
                if (|bus_if.req_valid) begin
                    accept_s = 1'b1;
                    ready_s  = grant_s;
                    state_d  = (cfg_ok_q && (win_op_s == cur_op_q)) ? EXEC : CFG;
                end else begin
                    state_d = IDLE;
                end
            end
            CFG:     state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the accepted operation and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            id_q  <= '0;
        end else if (accept_s) begin
            ptr_q <= (win_id_s == ID_W'(NUM_REQ - 1)) ? '0 : (win_id_s + ID_W'(1));
            op_q  <= win_op_s;
            a_q   <= win_a_s;
            b_q   <= shape_b(win_op_s, win_b_s);
            id_q  <= win_id_s;
        end
    end

    // Track which function the ALU currently holds; reset forces a reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_op_q <= 3'd0;
            cfg_ok_q <= 1'b0;
        end else if (state_q == CFG) begin
            cur_op_q <= op_q;
            cfg_ok_q <= 1'b1;
        end
    end

    // Capture the ALU result; holds until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= 32'd0;
            rsp_id_q   <= '0;
        end else if (state_q == EXEC) begin
            rsp_data_q <= bus_if.alu_out;
            rsp_id_q   <= id_q;
        end
    end

    // Registered strobes, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid_q <= 1'b0;
            alu_ctrl_q  <= 3'd0;
            rsp_valid_q <= 1'b0;
        end else begin
            alu_valid_q <= (state_d == CFG);
            alu_ctrl_q  <= (state_d == CFG) ? win_op_s : 3'd0;
            rsp_valid_q <= (state_d == DONE);
        end
    end

    assign bus_if.req_ready = ready_s;
    assign bus_if.rsp_valid = rsp_valid_q;
    assign bus_if.rsp_id    = rsp_id_q;
    assign bus_if.rsp_data  = rsp_data_q;
    assign bus_if.alu_valid = alu_valid_q;
    assign bus_if.alu_ctrl  = alu_ctrl_q;
    assign bus_if.alu_in_A  = a_q;
    assign bus_if.alu_in_B  = b_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched with a behavioural ALU that
// latches its function on alu_valid.
`timescale 1ns/1ps
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    alu_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    logic [2:0] alu_func_r;
    always @(posedge clk) begin
        if (bus.alu_valid) alu_func_r <= bus.alu_ctrl;
    end

    always_comb begin
        case (alu_func_r)
            FUNC_ADD: bus.alu_out = bus.alu_in_A + bus.alu_in_B;
            FUNC_SUB: bus.alu_out = bus.alu_in_A - bus.alu_in_B;
            FUNC_SLL: bus.alu_out = bus.alu_in_A << bus.alu_in_B[4:0];
            FUNC_XOR: bus.alu_out = bus.alu_in_A ^ bus.alu_in_B;
            FUNC_SRL: bus.alu_out = bus.alu_in_A >> bus.alu_in_B[4:0];
            FUNC_SRA: bus.alu_out = $unsigned($signed(bus.alu_in_A) >>> bus.alu_in_B[4:0]);
            FUNC_OR:  bus.alu_out = bus.alu_in_A | bus.alu_in_B;
            default:  bus.alu_out = bus.alu_in_A & bus.alu_in_B;
        endcase
    end

    typedef struct {
        logic [1:0]  id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_b;
        logic [31:0] exp_data;
        logic        exp_cfg;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] id, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_b, input logic [31:0] exp_data,
                          input logic exp_cfg);
        int          waited;
        int          rsp_k;
        int          pulses;
        int          cfg_pulses;
        logic        bad_ctrl;
        logic [31:0] got_data;
        logic [31:0] got_id;
        logic [31:0] in_b;
        rsp_k = 0; pulses = 0; cfg_pulses = 0; bad_ctrl = 1'b0;
        got_data = 32'd0; got_id = 32'd0; in_b = 32'd0;
        @(posedge clk); #1;
        bus.req_valid             = '0;
        bus.req_valid[id]         = 1'b1;
        bus.req_op[3*id +: 3]     = op;
        bus.req_a[32*id +: 32]    = a;
        bus.req_b[32*id +: 32]    = b;
        waited = 0;
        @(negedge clk);
        while (bus.req_ready[id] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check(tag, "req_ready", {28'd0, bus.req_ready}, 32'd1 << id);
        @(posedge clk); #1;
        bus.req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.alu_valid) begin
                cfg_pulses++;
                if (bus.alu_ctrl !== op) bad_ctrl = 1'b1;
            end else if (bus.alu_ctrl !== 3'd0) begin
                bad_ctrl = 1'b1;
            end
            if (k == 1) in_b = bus.alu_in_B;
            if (bus.rsp_valid) begin
                pulses++;
                rsp_k    = k;
                got_data = bus.rsp_data;
                got_id   = {30'd0, bus.rsp_id};
            end
        end
        check(tag, "cfg_pulses", cfg_pulses, {31'd0, exp_cfg});
        check(tag, "alu_ctrl_ok", {31'd0, bad_ctrl}, 32'd0);
        check(tag, "alu_in_B", in_b, exp_b);
        check(tag, "rsp_latency", rsp_k, exp_cfg ? 32'd3 : 32'd2);
        check(tag, "rsp_pulses", pulses, 32'd1);
        check(tag, "rsp_data", got_data, exp_data);
        check(tag, "rsp_id", got_id, {30'd0, id});
        check(tag, "rsp_hold", bus.rsp_data, exp_data);
    endtask

    task automatic expect_grant(input string tag, input int exp_id);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.req_ready === '0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check(tag, "grant", {28'd0, bus.req_ready}, 32'd1 << exp_id);
        @(posedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check(tag, "req_ready", {28'd0, bus.req_ready}, 32'd0);
        check(tag, "rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check(tag, "rsp_id", {30'd0, bus.rsp_id}, 32'd0);
        check(tag, "rsp_data", bus.rsp_data, 32'd0);
        check(tag, "alu_valid_ctrl", {28'd0, bus.alu_valid, bus.alu_ctrl}, 32'd0);
        check(tag, "alu_in_A", bus.alu_in_A, 32'd0);
        check(tag, "alu_in_B", bus.alu_in_B, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{2'd0, FUNC_ADD, 32'h00000005, 32'h00000003, 32'h00000003, 32'h00000008, 1'b1};
        vecs[1]  = '{2'd1, FUNC_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0};
        vecs[2]  = '{2'd2, FUNC_SRA, 32'h80000000, 32'hFFFFFFE4, 32'h00000004, 32'hF8000000, 1'b1};
        vecs[3]  = '{2'd3, FUNC_SUB, 32'h00000000, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{2'd0, FUNC_SUB, 32'h0000000A, 32'h00000003, 32'h00000003, 32'h00000007, 1'b0};
        vecs[5]  = '{2'd1, FUNC_SLL, 32'h00000001, 32'h00000023, 32'h00000003, 32'h00000008, 1'b1};
        vecs[6]  = '{2'd2, FUNC_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFF00FF00, 32'h0FF00FF0, 1'b1};
        vecs[7]  = '{2'd3, FUNC_SRL, 32'h80000000, 32'h0000001F, 32'h0000001F, 32'h00000001, 1'b1};
        vecs[8]  = '{2'd0, FUNC_OR,  32'h000000F0, 32'h00000F00, 32'h00000F00, 32'h00000FF0, 1'b1};
        vecs[9]  = '{2'd1, FUNC_AND, 32'hFFFF0000, 32'h12345678, 32'h12345678, 32'h12340000, 1'b1};
        vecs[10] = '{2'd2, FUNC_AND, 32'h0000000F, 32'h00000003, 32'h00000003, 32'h00000003, 1'b0};

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b,
                   vecs[v].exp_b, vecs[v].exp_data, vecs[v].exp_cfg);
        end

        // All four requesting from reset, then only 0 and 2.
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_op[3*i +: 3]  = FUNC_ADD;
            bus.req_a[32*i +: 32] = 32'(i);
            bus.req_b[32*i +: 32] = 32'd0;
        end
        bus.req_valid = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int g = 0; g < 4; g++) expect_grant($sformatf("rr_all%0d", g), g);
        #1 bus.req_valid = 4'b0101;
        expect_grant("rr_pair0", 0);
        expect_grant("rr_pair1", 2);
        #1 bus.req_valid = '0;
        repeat (6) @(posedge clk);

        // Reset while the hit-path operation is in EXEC.
        #1;
        bus.req_valid          = 4'b0010;
        bus.req_op[5:3]        = FUNC_ADD;
        bus.req_a[63:32]       = 32'd2;
        bus.req_b[63:32]       = 32'd2;
        @(negedge clk);
        check("midrst", "req_ready", {28'd0, bus.req_ready}, 32'd2);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("midrst", "no_cfg_on_hit", {31'd0, bus.alu_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        check("midrst", "rsp_valid_in_rst", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst", "rsp_valid_after", {31'd0, bus.rsp_valid}, 32'd0);
        run_op("post_rst", 2'd1, FUNC_ADD, 32'd2, 32'd2, 32'd2, 32'd4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares the single-issue ALU (the `valid`/`ctrl`/`in_A`/`in_B`/`out` datapath) among `NUM_REQ` requesters. It accepts one operation at a time and programs the ALU function only when the operation differs from the currently latched one. It then drives the operands, captures the result and returns it tagged with the requester ID. It sits between the requester-side logic and the ALU instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of requester ID, equal to clog2(`NUM_REQ`).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester request pending.
- `req_ready` out `NUM_REQ`: per-requester accept, one-hot or zero.
- `req_op` in 3*`NUM_REQ`: function code, slice i = [3i+2:3i].
- `req_a` in 32*`NUM_REQ`: operand A, slice i = [32i+31:32i].
- `req_b` in 32*`NUM_REQ`: operand B, same slicing.
- `rsp_valid` out 1: one-cycle result pulse.
- `rsp_id` out `ID_W`: requester that owns `rsp_data`.
- `rsp_data` out 32: ALU result.
- `alu_valid` out 1: ALU function-load strobe.
- `alu_ctrl` out 3: function code, meaningful only while `alu_valid` is 1.
- `alu_in_A` out 32: ALU operand A.
- `alu_in_B` out 32: ALU operand B.
- `alu_out` in 32: ALU result, combinational from the latched function and operands.

## Operation
- Function codes: ADD=0, SUB=1, SLL=2, XOR=3, SRL=4, SRA=5, OR=6, AND=7.
- ALU contract: on a rising edge with `alu_valid`=1, the ALU latches `alu_ctrl`. `alu_out` is then valid within the same cycle as operand changes.
- States:
  - IDLE:
    - If any `req_valid` is set, pick the winner by round-robin, starting at last grant + 1 modulo `NUM_REQ`.
    - Assert `req_ready[winner]` combinationally this cycle.
    - On the edge: latch op, A, B and ID, and update the pointer.
    - If `cfg_ok`=1 and the op equals `cur_op`, go to EXEC; otherwise go to CFG.
    - If no request is pending, stay in IDLE.
  - CFG:
    - Drive `alu_valid`=1 and `alu_ctrl`=latched op.
    - On the edge: `cur_op` ← op, `cfg_ok` ← 1, go to EXEC.
  - EXEC:
    - `alu_in_A`/`alu_in_B` come from the operand registers, which were updated at accept.
    - On the edge: `rsp_data` ← `alu_out`, go to DONE.
  - DONE:
    - `rsp_valid`=1 and `rsp_id`=latched ID.
    - Go to IDLE. No new request is accepted in DONE.
- Operand rule: for SLL, SRL and SRA, the stored B is {27'b0, B[4:0]}. For all other ops B is passed unchanged.
- Arithmetic is 32-bit modulo 2^32. The scheduler never checks or modifies results.
- `alu_valid`=0 and `alu_ctrl`=0 in every state except CFG.
- `req_ready` is 0 in every state except IDLE.
- A requester must hold op, A and B stable while `req_valid` is high and `req_ready` is low.

## Timing
- Reset values:
  - state IDLE; `req_ready` 0; `rsp_valid` 0; `rsp_id` 0; `rsp_data` 0.
  - `alu_valid` 0; `alu_ctrl` 0; `alu_in_A` 0; `alu_in_B` 0.
  - `cfg_ok` 0; `cur_op` 0.
  - Round-robin pointer set so requester 0 has highest priority.
- Latency, counted from the accept edge:
  - Function change (CFG path): `rsp_valid` is high in the 3rd cycle after the accept edge.
  - Function hit (no CFG): `rsp_valid` is high in the 2nd cycle after the accept edge.
- Throughput: one operation per 3 cycles on a function hit, 4 cycles on a change.
- Simultaneous requests: exactly one grant per accept. All other requesters wait with `req_ready`=0.
- Pointer wrap: after granting `NUM_REQ`-1, requester 0 has highest priority.
- Reset asserted mid-operation:
  - Immediate abort; no `rsp_valid` is produced.
  - `cfg_ok` clears, so the next operation always passes through CFG.
- `rsp_data` and `rsp_id` hold their values after DONE until the next capture.

## Structure
- Package `alu_sched_pkg`:
  - FUNC_* codes.
  - State enum IDLE/CFG/EXEC/DONE.
  - Helper function `is_shift(op)`.
- Sub-module `rr_arbiter`:
  - Parameter `NUM_REQ`.
  - Inputs: request vector, pointer.
  - Output: one-hot grant.
- The top level holds the FSM, operand/ID registers, `cur_op`/`cfg_ok` and the result register.

## Test plan
- After reset, req0 ADD A=0x00000005 B=0x00000003:
  - `alu_valid` pulses with `alu_ctrl`=0.
  - `rsp_data`=0x00000008, `rsp_id`=0, 3 cycles after accept.
- Then req1 ADD A=0xFFFFFFFF B=0x00000001:
  - No `alu_valid` pulse.
  - `rsp_data`=0x00000000, `rsp_id`=1, 2 cycles after accept.
- req2 SRA A=0x80000000 B=0xFFFFFFE4:
  - `alu_in_B`=0x00000004.
  - `rsp_data`=0xF8000000.
- All four `req_valid` held high from reset:
  - Grant order is 0, 1, 2, 3.
  - Then only req0 and req2 valid: order 0, 2.
- req3 SUB A=0x00000000 B=0x00000001 → `rsp_data`=0xFFFFFFFF.
- `rst_n` pulsed low during EXEC:
  - `rsp_valid` stays 0.
  - The next request with the same op still produces an `alu_valid` CFG pulse.
